// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - state and owner encodings shared by the memory bus arbiter
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner select between fetch and data requesters
// ARB_RR_EN defined: round-robin on ties; undefined: data always wins.
module mem_arb_pick
  import mem_bus_arbiter_pkg::*;
(
  input  logic inst_req,
  input  logic data_req,
  input  logic last_owner,
  output logic winner
);

`ifdef ARB_RR_EN
  always_comb begin
    winner = OWN_INST;
    if (inst_req && data_req) begin
      winner = (last_owner == OWN_INST) ? OWN_DATA : OWN_INST;
    end else if (data_req) begin
      winner = OWN_DATA;
    end
  end
`else
  // The MEM-stage stall freezes fetch, so starving inst here is harmless.
  logic w_unused;
  assign w_unused = last_owner ^ inst_req;
  assign winner   = data_req ? OWN_DATA : OWN_INST;
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one memory port between fetch and load/store requesters
// ARB_RR_EN defined adds a last-owner pointer for round-robin tie breaking.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_ok,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_be,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_ok,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;

  state_t            r_state;
  logic              r_owner;
  logic              r_mem_req;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [BE_W-1:0]   r_mem_be;
  logic [DATA_W-1:0] r_inst_rdata;
  logic [DATA_W-1:0] r_data_rdata;
  logic              r_inst_ok;
  logic              r_data_ok;
  logic              w_winner;
  logic              w_last_owner;

`ifdef ARB_RR_EN
  logic r_last;
  assign w_last_owner = r_last;
`else
  assign w_last_owner = OWN_INST;
`endif

  mem_arb_pick u_pick (
    .inst_req   (inst_req),
    .data_req   (data_req),
    .last_owner (w_last_owner),
    .winner     (w_winner)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_INST;
      r_mem_req    <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_be     <= '0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
      r_inst_ok    <= 1'b0;
      r_data_ok    <= 1'b0;
`ifdef ARB_RR_EN
      r_last       <= OWN_INST;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (inst_req || data_req) begin
            r_owner   <= w_winner;
            r_mem_req <= 1'b1;
            r_state   <= ST_ISSUE;
`ifdef ARB_RR_EN
            r_last    <= w_winner;
`endif
            if (w_winner == OWN_DATA) begin
              r_mem_addr  <= data_addr;
              r_mem_wr    <= data_wr;
              r_mem_wdata <= data_wdata;
              r_mem_be    <= data_wr ? data_be : '1;
            end else begin
              r_mem_addr  <= inst_addr;
              r_mem_wr    <= 1'b0;
              r_mem_wdata <= '0;
              r_mem_be    <= '1;
            end
          end
        end
        ST_ISSUE: begin
          // A same-cycle rvalid is dropped; memory never answers before the grant.
          if (mem_gnt) begin
            r_mem_req <= 1'b0;
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            if (r_owner == OWN_DATA) begin
              if (!r_mem_wr) r_data_rdata <= mem_rdata;
              r_data_ok <= 1'b1;
            end else begin
              r_inst_rdata <= mem_rdata;
              r_inst_ok    <= 1'b1;
            end
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_inst_ok <= 1'b0;
          r_data_ok <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_req    = r_mem_req;
  assign mem_wr     = r_mem_wr;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_be     = r_mem_be;
  assign inst_rdata = r_inst_rdata;
  assign data_rdata = r_data_rdata;
  assign inst_ok    = r_inst_ok;
  assign data_ok    = r_data_ok;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter (honours ARB_RR_EN)
module tb_mem_bus_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_ok;
  logic        data_req;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_be;
  logic [31:0] data_rdata;
  logic        data_ok;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_rdata (inst_rdata),
    .inst_ok    (inst_ok),
    .data_req   (data_req),
    .data_wr    (data_wr),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_be    (data_be),
    .data_rdata (data_rdata),
    .data_ok    (data_ok),
    .mem_req    (mem_req),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mreq_t;

  typedef struct {
    logic        own;
    logic [31:0] rdata;
    int          cyc;
  } rsp_t;

  localparam logic [31:0] I_A = 32'hBFC0_0010;
  localparam logic [31:0] D_A = 32'h8000_0100;

  mreq_t       mq[$];
  rsp_t        rsp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          req_cyc = 0;
  logic [31:0] exp_inst_rd = '0;
  logic [31:0] exp_data_rd = '0;

  logic        mem_en = 1'b0;
  int          gnt_dly = 0;
  int          rv_dly = 0;
  logic        use_fixed = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        f_gnt = 1'b0;
  logic        f_rvalid = 1'b0;
  logic [31:0] f_rdata = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rsp_of(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory model: auto mode applies grant/response delays, manual mode replays f_* values.
  initial begin
    int          gcnt;
    int          rcnt;
    logic        rpend;
    logic [31:0] raddr;
    gcnt = 0; rcnt = 0; rpend = 1'b0; raddr = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!mem_en) begin
        mem_gnt = f_gnt; mem_rvalid = f_rvalid; mem_rdata = f_rdata;
        gcnt = 0; rpend = 1'b0;
      end else begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        if (rpend) begin
          if (rcnt == rv_dly) begin
            mem_rvalid = 1'b1;
            mem_rdata  = use_fixed ? rsp_data : rsp_of(raddr);
            rpend      = 1'b0;
          end else rcnt++;
        end else if (mem_req) begin
          if (gcnt == gnt_dly) begin
            mem_gnt = 1'b1; gcnt = 0; rpend = 1'b1; rcnt = 0; raddr = mem_addr;
          end else gcnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    rsp_t e;
    if (mem_req) req_cyc++;
    if (inst_ok || data_ok) begin
      chk("ok_exclusive", {31'd0, inst_ok & data_ok}, 32'd0);
      if (rsp_q.size() == 0) begin
        chk("unexpected_ok", {30'd0, data_ok, inst_ok}, 32'd0);
      end else begin
        e = rsp_q.pop_front();
        chk("ok_owner", {31'd0, data_ok}, {31'd0, e.own});
        chk("ok_cycle", cyc, e.cyc);
        chk("ok_rdata", e.own ? data_rdata : inst_rdata, e.rdata);
      end
    end
    if (mem_req) begin
      if (mq.size() == 0) begin
        chk("unexpected_mem_req", {31'd0, mem_req}, 32'd0);
      end else begin
        chk("mem_addr", mem_addr, mq[0].addr);
        chk("mem_wr", {31'd0, mem_wr}, {31'd0, mq[0].wr});
        chk("mem_be", {28'd0, mem_be}, {28'd0, mq[0].be});
        if (mq[0].wr) chk("mem_wdata", mem_wdata, mq[0].wdata);
        if (mem_gnt) void'(mq.pop_front());
      end
    end
  end

  task automatic wait_ok(input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < 100 && seen < n; i++) begin
      @(negedge clk);
      if (inst_ok || data_ok) seen++;
    end
    chk("ok_count", seen, n);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_mem_wr"}, {31'd0, mem_wr}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_mem_be"}, {28'd0, mem_be}, 32'd0);
    chk({tag, "_oks"}, {30'd0, inst_ok, data_ok}, 32'd0);
    chk({tag, "_inst_rdata"}, inst_rdata, 32'd0);
    chk({tag, "_data_rdata"}, data_rdata, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    resetn = 1'b0; inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0;
    inst_addr = '0; data_addr = '0; data_wdata = '0; data_be = '0;
    mem_en = 1'b0; f_gnt = 1'b0; f_rvalid = 1'b0; f_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    exp_inst_rd = '0;
    exp_data_rd = '0;
    @(negedge clk);
    chk_zero("reset");
  endtask

  task automatic txn(input logic own, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     input logic [31:0] rdata, input int gd, input int rd);
    mreq_t m;
    rsp_t  r;
    mem_en = 1'b1; gnt_dly = gd; rv_dly = rd; use_fixed = 1'b1; rsp_data = rdata;
    @(posedge clk);
    #1;
    m.addr = addr; m.wr = own & wr; m.wdata = wdata; m.be = (own && wr) ? be : 4'hF;
    mq.push_back(m);
    r.own = own; r.cyc = cyc + 3 + gd + rd;
    if (!own) begin
      exp_inst_rd = rdata; r.rdata = rdata;
    end else if (!wr) begin
      exp_data_rd = rdata; r.rdata = rdata;
    end else begin
      r.rdata = exp_data_rd;
    end
    rsp_q.push_back(r);
    if (own) begin
      data_req = 1'b1; data_wr = wr; data_addr = addr; data_wdata = wdata; data_be = be;
    end else begin
      inst_req = 1'b1; inst_addr = addr;
    end
    wait_ok(1);
    inst_req = 1'b0; data_req = 1'b0;
  endtask

  // Requests held high across ok; order[k] is the owner of the k-th transaction (1 = data).
  task automatic burst(input logic ui, input logic ud, input logic [3:0] order, input int n);
    mreq_t m;
    rsp_t  r;
    mem_en = 1'b1; gnt_dly = 0; rv_dly = 0; use_fixed = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < n; k++) begin
      m.addr = order[k] ? D_A : I_A; m.wr = 1'b0; m.wdata = '0; m.be = 4'hF;
      mq.push_back(m);
      r.own = order[k]; r.rdata = rsp_of(m.addr); r.cyc = cyc + 3 + 4 * k;
      rsp_q.push_back(r);
      if (order[k]) exp_data_rd = r.rdata;
      else exp_inst_rd = r.rdata;
    end
    inst_req = ui; inst_addr = I_A;
    data_req = ud; data_wr = 1'b0; data_addr = D_A; data_be = 4'h1;
    wait_ok(n);
    inst_req = 1'b0; data_req = 1'b0;
  endtask

  initial begin
    int          c0;
    mreq_t       m;
    rsp_t        r;
    logic [31:0] old_i;
    do_reset();

    txn(1'b0, 1'b0, 32'hBFC0_0000, 32'h0, 4'h0, 32'h3C08_0001, 0, 0);
    chk("fetch_rdata", inst_rdata, 32'h3C08_0001);
    txn(1'b1, 1'b0, 32'h8000_0020, 32'h0, 4'h1, 32'hCAFE_F00D, 1, 2);

    c0 = req_cyc;
    txn(1'b1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'h3, 32'h1234_5678, 3, 0);
    chk("store_req_cycles", req_cyc - c0, 32'd4);
    chk("store_rdata_kept", data_rdata, 32'hCAFE_F00D);

    mem_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      f_gnt = 1'b1; f_rvalid = 1'b1; f_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("idle_spur_busy", {31'd0, busy}, 32'd0);
      chk("idle_spur_req", {31'd0, mem_req}, 32'd0);
      chk("idle_spur_ok", {30'd0, inst_ok, data_ok}, 32'd0);
      chk("idle_spur_inst_rd", inst_rdata, exp_inst_rd);
      chk("idle_spur_data_rd", data_rdata, exp_data_rd);
    end

    @(posedge clk);
    #1;
    f_gnt = 1'b0; f_rvalid = 1'b1; f_rdata = 32'hFFFF_0000;
    old_i = exp_inst_rd;
    m.addr = 32'h0040_0000; m.wr = 1'b0; m.wdata = '0; m.be = 4'hF;
    mq.push_back(m);
    r.own = 1'b0; r.rdata = 32'h1111_2222; r.cyc = cyc + 6;
    rsp_q.push_back(r);
    inst_req = 1'b1; inst_addr = 32'h0040_0000;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("issue_spur_busy", {31'd0, busy}, 32'd1);
      chk("issue_spur_req", {31'd0, mem_req}, 32'd1);
      chk("issue_spur_rd", inst_rdata, old_i);
    end
    @(posedge clk);
    #1;
    f_gnt = 1'b1; f_rvalid = 1'b1;
    @(posedge clk);
    #1;
    f_gnt = 1'b0; f_rvalid = 1'b0;
    @(negedge clk);
    chk("wait_rd_kept", inst_rdata, old_i);
    @(posedge clk);
    #1;
    f_rvalid = 1'b1; f_rdata = 32'h1111_2222;
    exp_inst_rd = 32'h1111_2222;
    wait_ok(1);
    inst_req = 1'b0; f_rvalid = 1'b0;

    burst(1'b1, 1'b0, 4'b0000, 2);

    mem_en = 1'b0; f_gnt = 1'b0; f_rvalid = 1'b0;
    @(posedge clk);
    #1;
    m.addr = 32'h8000_0040; m.wr = 1'b0; m.wdata = '0; m.be = 4'hF;
    mq.push_back(m);
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_0040; data_be = 4'hF;
    @(posedge clk);
    #1;
    f_gnt = 1'b1;
    @(posedge clk);
    #1;
    f_gnt = 1'b0; resetn = 1'b0; data_req = 1'b0;
    @(negedge clk);
    chk("abort_busy_wait", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    exp_inst_rd = '0; exp_data_rd = '0;
    @(negedge clk);
    chk_zero("abort");
    @(posedge clk);
    #1;
    f_rvalid = 1'b1; f_rdata = 32'h7777_7777;
    @(negedge clk);
    chk("late_rvalid_busy", {31'd0, busy}, 32'd0);
    chk("late_rvalid_rd", data_rdata, 32'd0);
    @(posedge clk);
    #1;
    f_rvalid = 1'b0;
    @(negedge clk);
    chk("late_rvalid_ok", {30'd0, inst_ok, data_ok}, 32'd0);

    do_reset();
`ifdef ARB_RR_EN
    burst(1'b1, 1'b1, 4'b0101, 3);
`else
    burst(1'b1, 1'b1, 4'b0111, 3);
`endif

    repeat (3) @(posedge clk);
    chk("rsp_queue_drained", rsp_q.size(), 32'd0);
    chk("mem_queue_drained", mq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the pipelined MIPS core. Each requester gets a one-cycle completion pulse. The pipeline's hazard logic stalls on the absence of that pulse. One transaction is outstanding at a time, and all memory-side outputs are registered.

## Interface
Parameters:
- ADDR_W, 32, address width for both requesters and the memory port
- DATA_W, 32, data width; byte-enable width is DATA_W/8

Ports:
- clk  in  1  system clock; all logic on the rising edge
- resetn  in  1  synchronous, active-low reset
- inst_req  in  1  fetch request; held high until inst_ok
- inst_addr  in  ADDR_W  fetch address
- inst_rdata  out  DATA_W  fetch data; valid when inst_ok=1
- inst_ok  out  1  one-cycle completion pulse for fetch
- data_req  in  1  load/store request; held high until data_ok
- data_wr  in  1  1 = store, 0 = load
- data_addr  in  ADDR_W  load/store address
- data_wdata  in  DATA_W  store data
- data_be  in  DATA_W/8  store byte enables
- data_rdata  out  DATA_W  load data; valid when data_ok=1
- data_ok  out  1  one-cycle completion pulse for load/store
- mem_req  out  1  memory request; held until mem_gnt
- mem_wr  out  1  write flag
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  DATA_W/8  memory byte enables; all ones for fetch and load
- mem_gnt  in  1  memory accepted the request this cycle
- mem_rvalid  in  1  response (read data or write ack) this cycle
- mem_rdata  in  DATA_W  response data
- busy  out  1  high in every state except IDLE

## Operation
FSM states are IDLE, ISSUE, WAIT and RESP.

- **IDLE**
  - If neither request is high, stay in IDLE.
  - Otherwise pick a winner per Configuration.
  - Latch the winner's addr/wr/wdata/be into the mem_* registers. For inst, wr=0 and be=all ones.
  - Record the owner and go to ISSUE.
- **ISSUE**
  - mem_req=1.
  - On mem_gnt=1, go to WAIT.
  - Otherwise stay in ISSUE; mem_* outputs stay stable.
- **WAIT**
  - mem_req=0.
  - On mem_rvalid=1, latch mem_rdata into the owner's rdata register and go to RESP.
- **RESP**
  - The owner's ok=1 for exactly this cycle. Then go to IDLE.

Rules that apply in every state:
- Requester inputs are sampled only in IDLE. Changes in any other state are ignored.
- A request still high in the IDLE cycle after ok is a new request.
- mem_gnt outside ISSUE is ignored. mem_rvalid outside WAIT is ignored.
- inst_ok and data_ok are never high in the same cycle.
- rdata registers hold their last value until overwritten. For stores, data_rdata is unchanged.
- Writes complete on mem_rvalid exactly as reads do; mem_rdata is ignored for stores.

## Timing
- Reset values: state=IDLE. All outputs are 0, including mem_be, inst_rdata, data_rdata and the round-robin pointer (last=inst).
- Minimum latency: req sampled in IDLE at cycle 0, mem_req=1 at cycle 1, gnt at cycle 1, rvalid at cycle 2, ok=1 at cycle 3, IDLE again at cycle 4.
- Total latency is 4 + (gnt wait cycles) + (rvalid wait cycles).
- Back-to-back throughput is one transaction per 4 cycles minimum.
- A requester drops or replaces its req starting the cycle after ok.
- Reset mid-operation:
  - resetn=0 in any state forces IDLE on the next edge and drops mem_req.
  - No ok is issued for the aborted transaction.
  - The memory is reset by the same resetn.
- Simultaneous gnt and rvalid in ISSUE: gnt is taken and rvalid is ignored. The memory never returns a response before the grant.

## Configuration
- ARB_RR_EN defined:
  - Round-robin. When both requests are high, the requester not granted last wins.
  - The pointer updates on every IDLE→ISSUE transition.
  - After reset (last=inst), data wins the first tie.
- ARB_RR_EN undefined:
  - Fixed priority: data always beats inst.
  - No pointer register exists.
  - This is acceptable because the MEM-stage stall halts fetch.

## Structure
- A shared package holds:
  - the state encoding constants ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP (2-bit);
  - the owner constants OWN_INST=0 and OWN_DATA=1.
- One sub-module, mem_arb_pick, is natural. It is combinational: inputs inst_req, data_req and last_owner; output winner. It contains the ARB_RR_EN selection.

## Test plan
- **Single fetch:** inst_req=1, inst_addr=0xBFC00000; gnt immediately, rvalid the next cycle with 0x3C080001. Required: mem_addr=0xBFC00000, mem_wr=0, mem_be=0xF; inst_ok pulses at cycle 3 with inst_rdata=0x3C080001; data_ok stays 0.
- **Store with delayed gnt:** data_req=1, data_wr=1, addr=0x80000010, wdata=0xDEADBEEF, be=0x3; gnt delayed 3 cycles. Required: mem_req stays high 4 cycles with stable outputs; data_ok pulses once; data_rdata unchanged.
- **Simultaneous requests, ARB_RR_EN defined:** both held high for 3 transactions. Required grant order data, inst, data. With the macro undefined, the order is data, data, data.
- **Spurious responses:** mem_rvalid=1 in IDLE and in ISSUE. Required: no ok pulse, no state change, rdata registers unchanged.
- **Reset mid-transaction:** resetn=0 for 1 cycle while in WAIT. Required: IDLE next cycle, all outputs 0, no ok for the aborted transaction; a later rvalid=1 is ignored.
- **Held request:** inst_req held high across ok. Required: a second transaction starts in the IDLE cycle after RESP, and ok pulses are exactly 4 cycles apart with zero-wait memory.
